ej32_pfq: RTL and testbench
===========================

# ej32_pfq

Instruction prefetch queue between the 8-bit program memory port and the eJ32 decoder. It streams bytecode bytes from sequential addresses into a small byte FIFO and presents the opcode plus up to two following operand bytes to the decoder each cycle. The decoder consumes 0–3 bytes per cycle, and a branch flushes the queue and restarts fetch at the target. It replaces the single-byte `p`/`p_inc` sequencing with a decoupled, bus-tolerant fetch stage.

## Interface
- `ASZ`, 17, address width
- `DEPTH`, 4, FIFO depth in bytes (power of two, ≥4)
- `COLD`, 'h0, fetch address after reset
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mem_req`  out  1  fetch request
- `mem_a`  out  ASZ  fetch byte address
- `mem_gnt`  in  1  request accepted this cycle (LS unit may hold the bus)
- `mem_d`  in  8  returned byte, valid the cycle after `mem_req & mem_gnt`
- `br_en`  in  1  flush and redirect
- `br_p`  in  ASZ  redirect target
- `ir_vld`  out  1  `cnt ≥ 1`
- `op`  out  8  head byte
- `opnd`  out  16  {head+1, head+2}; bytes beyond `cnt` read as 0
- `cnt`  out  3  valid bytes at head, saturating at `DEPTH`
- `ir_p`  out  ASZ  address of `op`
- `take`  in  2  bytes consumed this cycle (0–3)
- `stat_flush`, `stat_empty`  out  16 each  statistics (see Configuration)

## Operation
- Fetch FSM states: FILL, FULL, KILL.
  - FILL: `mem_req=1`, `mem_a=fa`.
  - FILL→FULL when occupancy + in-flight reaches `DEPTH` after this cycle's push/pop.
  - FULL→FILL when a slot frees.
- On a grant, `fa` increments by 1 and modulo 2^ASZ wraps to 0. One byte at most is in flight.
- The returned byte is pushed at the tail the cycle after the grant.
- Pop: the head advances by `take`, and `ir_p` advances by `take` with wrap.
  - `take > cnt` is illegal. It asserts in simulation; the RTL clamps it to `cnt`.
- Push and pop in the same cycle are both honoured. Occupancy updates as `occ + push − take`.
- `br_en`:
  - Occupancy goes to 0, `fa` and `ir_p` are loaded from `br_p`, and `take` is ignored. `br_en` has priority over `take` and over push.
  - If a byte is in flight, or granted in the `br_en` cycle, the FSM enters KILL. KILL discards the next `mem_d` and returns to FILL. `mem_req` is held 0 while in KILL.
  - A `br_en` that arrives while in KILL stays in KILL and reloads `br_p`.
- `mem_gnt=0` holds `mem_req`/`mem_a` stable. There is no timeout.

## Timing
- Reset values:
  - `mem_req=0`, `mem_a=COLD`
  - `ir_vld=0`, `op=0`, `opnd=0`, `cnt=0`, `ir_p=COLD`
  - state FILL, stats 0
- `mem_req` first rises in the first cycle after reset deassertion.
- Latency: a request granted in cycle n makes the byte visible on `op`/`cnt` in cycle n+2 (registered push).
- Streaming at full grant: 1 byte/cycle sustained. The queue never starves when `take ≤ 1`.
- Redirect: with `br_en` at cycle n, `mem_a=br_p` with `mem_req=1` at n+1 (no in-flight byte) or at n+2 (KILL). The first target byte appears at n+3 or n+4 respectively.
- All outputs are registered except `ir_vld`, `op`, `opnd` and `cnt`, which are decoded directly from the queue registers, with no input-to-output combinational path.
- Reset asserted mid-operation returns every register immediately to its reset value. A returning `mem_d` is ignored until the first post-reset grant.

## Configuration
- `PFQ_STAT_EN` defined:
  - `stat_flush` counts `br_en` cycles.
  - `stat_empty` counts cycles with `cnt==0` while not in reset.
  - Both saturate at 'hFFFF and reset to 0.
- Not defined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Reset with memory bytes 'h10,'h11,'h12,'h13 at addresses 0..3, `take=0`, grant always:
  - `op='h10`, `opnd='h1112`, `ir_p=0`, `cnt` reaches 4.
  - `mem_req` drops (FULL).
- Steady `take=1` with grant always:
  - `op` walks 'h10,'h11,… one per cycle with no bubble.
  - `ir_p` increments by 1 per cycle.
- `take=3` with a full queue:
  - The next cycle shows `op='h13`, `ir_p=3`, `cnt=1`.
  - Refill restores `cnt=4` within 4 cycles.
- `br_en` with `br_p='h0100` while a byte is in flight:
  - The in-flight byte is discarded and `cnt=0` next cycle.
  - `mem_a='h0100` at n+2, and `op` equals mem['h0100] at n+4.
- Wrap case, starting at `br_p='h1FFFF` with grant always:
  - Bytes from 'h1FFFF, then 0, then 1 appear in order.
- Grant withheld for 5 cycles:
  - `mem_a` is stable throughout.
  - `cnt` drains to 0 under `take=1`.
  - With `PFQ_STAT_EN` defined, `stat_empty` increments once per empty cycle.

Source files
------------

// File: rtl/ej32_pfq.sv
// ej32_pfq: eJ32 bytecode prefetch queue feeding opcode + two operand bytes to the decoder.
// Define PFQ_STAT_EN to build the flush/empty statistics counters.
module ej32_pfq #(
  parameter int ASZ = 17,
  parameter int DEPTH = 4,
  parameter logic [ASZ-1:0] COLD = '0
) (
  input  logic           clk,
  input  logic           rst,
  output logic           mem_req,
  output logic [ASZ-1:0] mem_a,
  input  logic           mem_gnt,
  input  logic [7:0]     mem_d,
  input  logic           br_en,
  input  logic [ASZ-1:0] br_p,
  output logic           ir_vld,
  output logic [7:0]     op,
  output logic [15:0]    opnd,
  output logic [2:0]     cnt,
  output logic [ASZ-1:0] ir_p,
  input  logic [1:0]     take,
  output logic [15:0]    stat_flush,
  output logic [15:0]    stat_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int CM = DEPTH > 7 ? 7 : DEPTH;
  localparam logic [1:0] FILL = 2'd0, FULL = 2'd1, KILL = 2'd2;
  logic [1:0] st_q, st_d;
  logic req_q, req_d, fl_q, fl_d, push;
  logic [ASZ-1:0] fa_q, fa_d, irp_q, irp_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [AW-1:0] hd_q, hd_d, tl_q, tl_d;
  logic [7:0] qb_q [DEPTH];
  logic [1:0] tk;
  // fl_q marks the byte granted last cycle, arriving on mem_d now; KILL drops it
  always_comb begin
    tk = br_en ? 2'd0 : (OW'(take) > occ_q) ? occ_q[1:0] : take;
    push = fl_q && st_q != KILL && !br_en;
    fl_d = req_q && mem_gnt;
    fa_d = br_en ? br_p : fl_d ? fa_q + ASZ'(1) : fa_q;
    irp_d = br_en ? br_p : irp_q + ASZ'(tk);
    occ_d = br_en ? '0 : occ_q + OW'(push) - OW'(tk);
    hd_d = br_en ? '0 : hd_q + AW'(tk);
    tl_d = br_en ? '0 : tl_q + AW'(push);
    st_d = br_en ? ((fl_q || fl_d || st_q == KILL) ? KILL : FILL)
         : st_q == KILL ? FILL
         : (occ_d + OW'(fl_d) >= OW'(DEPTH)) ? FULL : FILL;
    req_d = st_d == FILL;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= FILL;
      req_q <= 1'b0;
      fl_q <= 1'b0;
      fa_q <= COLD;
      irp_q <= COLD;
      occ_q <= '0;
      hd_q <= '0;
      tl_q <= '0;
      for (int i = 0; i < DEPTH; i++) qb_q[i] <= 8'h00;
    end else begin
      st_q <= st_d;
      req_q <= req_d;
      fl_q <= fl_d;
      fa_q <= fa_d;
      irp_q <= irp_d;
      occ_q <= occ_d;
      hd_q <= hd_d;
      tl_q <= tl_d;
      if (push) qb_q[tl_q] <= mem_d;
    end
  end
  assign mem_req = req_q;
  assign mem_a = fa_q;
  assign ir_p = irp_q;
  assign ir_vld = occ_q != '0;
  assign cnt = (occ_q >= OW'(CM)) ? 3'(CM) : 3'(occ_q);
  assign op = ir_vld ? qb_q[hd_q] : 8'h00;
  assign opnd = {occ_q >= OW'(2) ? qb_q[hd_q + AW'(1)] : 8'h00,
                 occ_q >= OW'(3) ? qb_q[hd_q + AW'(2)] : 8'h00};
  assert property (@(posedge clk) disable iff (!rst) !br_en |-> OW'(take) <= occ_q);
`ifdef PFQ_STAT_EN
  logic [15:0] sf_q, se_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sf_q <= '0;
      se_q <= '0;
    end else begin
      if (br_en && sf_q != 16'hFFFF) sf_q <= sf_q + 16'd1;
      if (occ_q == '0 && se_q != 16'hFFFF) se_q <= se_q + 16'd1;
    end
  end
  assign stat_flush = sf_q;
  assign stat_empty = se_q;
`else
  assign stat_flush = '0;
  assign stat_empty = '0;
`endif
endmodule

// File: tb/tb_ej32_pfq.sv
// tb_ej32_pfq: directed self-checking bench for ej32_pfq; memory byte at a = 'h10 + a[7:0] + a[15:8] + (a[16] ? 'h80 : 0).
module tb_ej32_pfq;
  logic clk = 1'b0, rst = 1'b0, mem_req, mem_gnt = 1'b1, br_en = 1'b0, ir_vld;
  logic [16:0] mem_a, br_p = '0, ir_p;
  logic [7:0] mem_d = 8'hEE, op;
  logic [15:0] opnd, stat_flush, stat_empty;
  logic [2:0] cnt;
  logic [1:0] take = 2'd0;
  int checks = 0, errors = 0;
`ifdef PFQ_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif
  ej32_pfq dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_a(mem_a), .mem_gnt(mem_gnt), .mem_d(mem_d),
    .br_en(br_en), .br_p(br_p), .ir_vld(ir_vld), .op(op), .opnd(opnd), .cnt(cnt), .ir_p(ir_p),
    .take(take), .stat_flush(stat_flush), .stat_empty(stat_empty)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] f(input logic [16:0] a);
    return 8'h10 + a[7:0] + a[15:8] + (a[16] ? 8'h80 : 8'h00);
  endfunction
  always @(posedge clk) mem_d <= (mem_req && mem_gnt) ? f(mem_a) : 8'hEE;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    cyc(2);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_a", 32'(mem_a), 0);
    chk("rst_vld", 32'(ir_vld), 0);
    chk("rst_op", 32'(op), 0);
    chk("rst_opnd", 32'(opnd), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_irp", 32'(ir_p), 0);
    chk("rst_sflush", 32'(stat_flush), 0);
    chk("rst_sempty", 32'(stat_empty), 0);
    rst = 1'b1;
    cyc(1);
    chk("first_req", 32'(mem_req), 1);
    chk("first_a", 32'(mem_a), 0);
    cyc(2);
    chk("lat_op", 32'(op), 'h10);
    chk("lat_cnt", 32'(cnt), 1);
    cyc(3);
    chk("fill_cnt", 32'(cnt), 4);
    chk("fill_op", 32'(op), 'h10);
    chk("fill_opnd", 32'(opnd), 'h1112);
    chk("fill_irp", 32'(ir_p), 0);
    chk("full_req", 32'(mem_req), 0);
    chk("full_a", 32'(mem_a), 4);
    chk("fill_sempty", 32'(stat_empty), STAT ? 3 : 0);
    take = 2'd1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      chk("walk_op", 32'(op), 32'('h10 + k));
      chk("walk_irp", 32'(ir_p), 32'(k));
    end
    chk("walk_cnt", 32'(cnt), 2);
    take = 2'd0;
    cyc(2);
    chk("refull_cnt", 32'(cnt), 4);
    chk("refull_req", 32'(mem_req), 0);
    chk("refull_opnd", 32'(opnd), 'h1718);
    take = 2'd3;
    cyc(1);
    chk("t3_op", 32'(op), 'h19);
    chk("t3_irp", 32'(ir_p), 9);
    chk("t3_cnt", 32'(cnt), 1);
    chk("t3_req", 32'(mem_req), 1);
    chk("t3_a", 32'(mem_a), 'hA);
    take = 2'd0;
    cyc(2);
    chk("refill2_cnt", 32'(cnt), 2);
    cyc(2);
    chk("refill4_cnt", 32'(cnt), 4);
    chk("refill4_opnd", 32'(opnd), 'h1A1B);
    chk("refill4_a", 32'(mem_a), 'hD);
    take = 2'd1;
    cyc(2);
    chk("prebr_op", 32'(op), 'h1B);
    chk("prebr_irp", 32'(ir_p), 'hB);
    br_en = 1'b1;
    br_p = 17'h00100;
    take = 2'd2;
    cyc(1);
    chk("br_cnt", 32'(cnt), 0);
    chk("br_vld", 32'(ir_vld), 0);
    chk("br_irp", 32'(ir_p), 'h100);
    chk("kill_req", 32'(mem_req), 0);
    chk("br_sflush", 32'(stat_flush), STAT ? 1 : 0);
    br_en = 1'b0;
    take = 2'd0;
    cyc(1);
    chk("br_n2_req", 32'(mem_req), 1);
    chk("br_n2_a", 32'(mem_a), 'h100);
    cyc(2);
    chk("br_n4_op", 32'(op), 'h11);
    chk("br_n4_cnt", 32'(cnt), 1);
    chk("br_n4_opnd", 32'(opnd), 0);
    chk("br_n4_irp", 32'(ir_p), 'h100);
    chk("br_sempty", 32'(stat_empty), STAT ? 6 : 0);
    cyc(1);
    chk("part_cnt", 32'(cnt), 2);
    chk("part_opnd", 32'(opnd), 'h1200);
    br_en = 1'b1;
    br_p = 17'h1FFFF;
    cyc(1);
    chk("wbr_cnt", 32'(cnt), 0);
    chk("wbr_req", 32'(mem_req), 0);
    br_en = 1'b0;
    cyc(1);
    chk("wrap_a0", 32'(mem_a), 'h1FFFF);
    chk("wrap_req", 32'(mem_req), 1);
    cyc(1);
    chk("wrap_a1", 32'(mem_a), 0);
    cyc(1);
    chk("wrap_op", 32'(op), 'h8E);
    chk("wrap_cnt", 32'(cnt), 1);
    chk("wrap_irp", 32'(ir_p), 'h1FFFF);
    chk("wrap_a2", 32'(mem_a), 1);
    chk("wrap_sempty", 32'(stat_empty), STAT ? 9 : 0);
    chk("wrap_sflush", 32'(stat_flush), STAT ? 2 : 0);
    cyc(1);
    chk("wrap_opnd1", 32'(opnd), 'h1000);
    cyc(1);
    chk("wrap_cnt3", 32'(cnt), 3);
    chk("wrap_opnd2", 32'(opnd), 'h1011);
    chk("wrap_full", 32'(mem_req), 0);
    take = 2'd1;
    mem_gnt = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk("hold_a", 32'(mem_a), 3);
      chk("hold_req", 32'(mem_req), 1);
      chk("drain_cnt", 32'(cnt), k < 3 ? 32'(3 - k) : 0);
      chk("drain_irp", 32'(ir_p), k < 4 ? 32'(k) : 3);
      if (k < 3) chk("drain_op", 32'(op), 32'('h10 + k));
      if (k == 3) take = 2'd0;
    end
    chk("hold_vld", 32'(ir_vld), 0);
    chk("hold_sempty", 32'(stat_empty), STAT ? 11 : 0);
    mem_gnt = 1'b1;
    cyc(2);
    chk("resume_op", 32'(op), 'h13);
    chk("resume_cnt", 32'(cnt), 1);
    chk("resume_irp", 32'(ir_p), 3);
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_a", 32'(mem_a), 0);
    chk("arst_cnt", 32'(cnt), 0);
    chk("arst_irp", 32'(ir_p), 0);
    chk("arst_sflush", 32'(stat_flush), 0);
    chk("arst_sempty", 32'(stat_empty), 0);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("rel_req", 32'(mem_req), 1);
    chk("rel_a", 32'(mem_a), 0);
    mem_gnt = 1'b0;
    br_en = 1'b1;
    br_p = 17'h00200;
    cyc(1);
    chk("nbr_req", 32'(mem_req), 1);
    chk("nbr_a", 32'(mem_a), 'h200);
    chk("nbr_cnt", 32'(cnt), 0);
    br_en = 1'b0;
    mem_gnt = 1'b1;
    cyc(2);
    chk("nbr_op", 32'(op), 'h12);
    chk("nbr_cnt1", 32'(cnt), 1);
    chk("nbr_irp", 32'(ir_p), 'h200);
    chk("nbr_sflush", 32'(stat_flush), STAT ? 1 : 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
